region_ram_arbiter: RTL and testbench

REGION_RAM_ARBITER -- requirements
Module: region_ram_arbiter

---
 rtl/region_pkg.sv | 26 ++
 rtl/region_ram_arbiter.sv | 157 +++++++++++++++
 tb/tb_region_ram_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/region_pkg.sv
// Shared constants and FSM encoding for the region boundary RAM arbiter.
package region_pkg;

    localparam int unsigned NUM_POINTS  = 812;
    localparam int unsigned DATA_W      = 18;
    localparam int unsigned NUM_REGIONS = 3;
    localparam int unsigned ADDR_W      = 10;
    localparam int unsigned REGION_W    = 2;

    typedef enum logic [1:0] {
        ST_ARB  = 2'd0,
        ST_PEND = 2'd1,
        ST_SWAP = 2'd2
    } arb_state_e;

    // One-hot RAM select for a region index; out-of-range indices select nothing.
    function automatic logic [NUM_REGIONS-1:0] region_onehot(input logic [REGION_W-1:0] region);
        logic [NUM_REGIONS-1:0] sel;
        sel = '0;
        for (int unsigned r = 0; r < NUM_REGIONS; r++) begin
            if (region == REGION_W'(r)) sel[r] = 1'b1;
        end
        return sel;
    endfunction

endpackage

// File: rtl/region_ram_arbiter.sv
// Arbitrates three single-port region RAMs between the compare engine (always wins)
// and a host port writing the shadow bank, with a safe-point bank swap on commit.
module region_ram_arbiter #(
    parameter int unsigned NUM_POINTS = region_pkg::NUM_POINTS,
    parameter int unsigned DATA_W     = region_pkg::DATA_W
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      cycle_enable,
    input  logic                                      cmp_rden,
    input  logic [region_pkg::ADDR_W-1:0]             cmp_rdaddr,
    output logic [region_pkg::NUM_REGIONS*DATA_W-1:0] cmp_rddata,
    input  logic                                      host_req,
    input  logic                                      host_we,
    input  logic [region_pkg::REGION_W-1:0]           host_region,
    input  logic [region_pkg::ADDR_W-1:0]             host_addr,
    input  logic [DATA_W-1:0]                         host_wdata,
    output logic                                      host_ack,
    output logic                                      host_err,
    output logic                                      host_rvalid,
    output logic [DATA_W-1:0]                         host_rdata,
    input  logic                                      commit,
    output logic                                      commit_pending,
    output logic                                      active_bank,
    output logic [region_pkg::NUM_REGIONS-1:0]        ram_rden,
    output logic [region_pkg::NUM_REGIONS-1:0]        ram_wren,
    output logic [region_pkg::ADDR_W:0]               ram_addr,
    output logic [DATA_W-1:0]                         ram_wdata,
    input  logic [region_pkg::NUM_REGIONS*DATA_W-1:0] ram_rddata
);
    import region_pkg::*;

    localparam int unsigned        RD_W       = NUM_REGIONS * DATA_W;
    localparam logic [ADDR_W:0]    ADDR_LIMIT = (ADDR_W + 1)'(NUM_POINTS);

    arb_state_e            state_q;
    logic                  active_bank_q;
    logic                  commit_pending_q;

    logic                  host_grant;
    logic                  host_bad;
    logic                  host_ok;

    logic                  rd_inflight_q;
    logic [REGION_W-1:0]   rd_region_q;
    logic                  rvalid_q;
    logic [DATA_W-1:0]     rdata_q;
    logic [DATA_W-1:0]     rd_slice;

    logic                  cmp_vld_q;
    logic [RD_W-1:0]       cmp_hold_q;

    // Host is served only in idle cycles of the compare engine and only in ARB.
    always_comb begin
        host_grant = !rst && (state_q == ST_ARB) && !cmp_rden && host_req;
        host_bad   = ({1'b0, host_addr} >= ADDR_LIMIT) || (host_region >= REGION_W'(NUM_REGIONS));
        host_ok    = host_grant && !host_bad;
    end

    assign host_ack = host_grant;
    assign host_err = host_grant && host_bad;

    always_comb begin
        ram_rden  = '0;
        ram_wren  = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (!rst) begin
            if (cmp_rden) begin
                ram_rden = '1;
                ram_addr = {active_bank_q, cmp_rdaddr};
            end else if (host_ok) begin
                ram_addr = {~active_bank_q, host_addr};
                if (host_we) begin
                    ram_wren  = region_onehot(host_region);
                    ram_wdata = host_wdata;
                end else begin
                    ram_rden = region_onehot(host_region);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_ARB;
            active_bank_q    <= 1'b0;
            commit_pending_q <= 1'b0;
        end else begin
            case (state_q)
                ST_ARB: begin
                    if (commit) begin
                        state_q          <= ST_PEND;
                        commit_pending_q <= 1'b1;
                    end
                end
                ST_PEND: begin
                    if (!cycle_enable && !cmp_rden && !rd_inflight_q) begin
                        state_q <= ST_SWAP;
                    end
                end
                ST_SWAP: begin
                    state_q          <= ST_ARB;
                    active_bank_q    <= ~active_bank_q;
                    commit_pending_q <= 1'b0;
                end
                default: begin
                    state_q          <= ST_ARB;
                    commit_pending_q <= 1'b0;
                end
            endcase
        end
    end

    assign active_bank    = active_bank_q;
    assign commit_pending = commit_pending_q;

    always_comb begin
        rd_slice = '0;
        for (int unsigned r = 0; r < NUM_REGIONS; r++) begin
            if (rd_region_q == REGION_W'(r)) rd_slice = ram_rddata[r*DATA_W +: DATA_W];
        end
    end

    // Host read: RAM data appears at T+1, captured so rvalid/rdata show at T+2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_inflight_q <= 1'b0;
            rd_region_q   <= '0;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
        end else begin
            rd_inflight_q <= host_ok && !host_we;
            if (host_ok) rd_region_q <= host_region;
            rvalid_q <= rd_inflight_q;
            if (rd_inflight_q) rdata_q <= rd_slice;
        end
    end

    assign host_rvalid = rvalid_q;
    assign host_rdata  = rdata_q;

    // Compare data bypasses straight from the RAMs, then is held so host reads
    // on the shared read bus never reach the compare engine.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_vld_q  <= 1'b0;
            cmp_hold_q <= '0;
        end else begin
            cmp_vld_q <= cmp_rden;
            if (cmp_vld_q) cmp_hold_q <= ram_rddata;
        end
    end

    assign cmp_rddata = cmp_vld_q ? ram_rddata : cmp_hold_q;

endmodule

// File: tb/tb_region_ram_arbiter.sv
// Scoreboard bench for region_ram_arbiter with behavioural RAMs and directed vectors.
module tb_region_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cycle_enable = 1'b0;
    logic        cmp_rden = 1'b0;
    logic [9:0]  cmp_rdaddr = '0;
    logic [53:0] cmp_rddata;
    logic        host_req = 1'b0;
    logic        host_we = 1'b0;
    logic [1:0]  host_region = '0;
    logic [9:0]  host_addr = '0;
    logic [17:0] host_wdata = '0;
    logic        host_ack, host_err, host_rvalid;
    logic [17:0] host_rdata;
    logic        commit = 1'b0;
    logic        commit_pending, active_bank;
    logic [2:0]  ram_rden, ram_wren;
    logic [10:0] ram_addr;
    logic [17:0] ram_wdata;
    logic [53:0] ram_rddata;

    always #5 clk = ~clk;

    region_ram_arbiter #(.NUM_POINTS(812), .DATA_W(18)) dut (
        .clk(clk), .rst(rst), .cycle_enable(cycle_enable),
        .cmp_rden(cmp_rden), .cmp_rdaddr(cmp_rdaddr), .cmp_rddata(cmp_rddata),
        .host_req(host_req), .host_we(host_we), .host_region(host_region),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack),
        .host_err(host_err), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .commit(commit), .commit_pending(commit_pending), .active_bank(active_bank),
        .ram_rden(ram_rden), .ram_wren(ram_wren), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rddata(ram_rddata)
    );

    // Three single-port RAMs, one-cycle read latency.
    logic [17:0] mem [3][2048];
    logic [17:0] rd_r [3];
    always @(posedge clk) begin
        for (int r = 0; r < 3; r++) begin
            if (ram_wren[r]) mem[r][ram_addr] = ram_wdata;
            if (ram_rden[r]) rd_r[r] <= mem[r][ram_addr];
        end
    end
    assign ram_rddata = {rd_r[2], rd_r[1], rd_r[0]};

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    typedef struct {
        logic        err;
        logic [2:0]  rden;
        logic [2:0]  wren;
        logic [10:0] addr;
        logic        is_read;
        logic [17:0] rdata;
    } ack_exp_t;
    typedef struct {
        logic [17:0] data;
        int unsigned due;
    } rd_exp_t;
    typedef struct {
        logic [10:0] addr;
        logic [53:0] data;
    } cmp_exp_t;

    ack_exp_t ack_q[$];
    rd_exp_t  due_q[$];
    cmp_exp_t cmp_q[$];

    logic     bank_exp = 1'b0;

    // Monitor: pops expectations whenever the DUT presents a response.
    ack_exp_t    ma;
    rd_exp_t     mr;
    cmp_exp_t    mc;
    logic        cmp_pend = 1'b0;
    logic [53:0] cmp_pend_data = '0;
    logic [53:0] hold_exp = '0;

    always @(negedge clk) begin
        if (rst) begin
            due_q.delete();
            cmp_pend = 1'b0;
            hold_exp = '0;
        end else begin
            if (cmp_pend) begin
                check("cmp_rddata", cmp_rddata, cmp_pend_data);
                hold_exp = cmp_pend_data;
            end else begin
                check("cmp_hold", cmp_rddata, hold_exp);
            end
            cmp_pend = 1'b0;
            if (cmp_rden) begin
                if (cmp_q.size() == 0) fail_now("cmp_unexpected_read");
                else begin
                    mc = cmp_q.pop_front();
                    check("cmp_strobe", ram_rden, 3'b111);
                    check("cmp_addr", ram_addr, mc.addr);
                    cmp_pend      = 1'b1;
                    cmp_pend_data = mc.data;
                end
            end
            if (host_ack) begin
                if (ack_q.size() == 0) fail_now("host_ack_unexpected");
                else begin
                    ma = ack_q.pop_front();
                    check("host_err", host_err, ma.err);
                    check("host_rden", ram_rden, ma.rden);
                    check("host_wren", ram_wren, ma.wren);
                    if (!ma.err) check("host_addr", ram_addr, ma.addr);
                    if (ma.is_read && !ma.err) due_q.push_back('{ma.rdata, cyc + 2});
                end
            end else begin
                check("err_without_ack", host_err, 1'b0);
            end
            if (host_rvalid) begin
                if (due_q.size() == 0) fail_now("host_rvalid_unexpected");
                else begin
                    mr = due_q.pop_front();
                    check("host_rdata", host_rdata, mr.data);
                    check("rvalid_cycle", cyc, mr.due);
                end
            end
        end
    end

    task automatic push_ack(input logic err, input logic [2:0] rden, input logic [2:0] wren,
                            input logic [9:0] a, input logic rd, input logic [17:0] d);
        ack_q.push_back('{err, rden, wren, {~bank_exp, a}, rd, d});
    endtask

    // All stimulus tasks start and end one time unit after a rising edge.
    task automatic host_access(input logic we, input logic [1:0] region, input logic [9:0] a,
                               input logic [17:0] wd, input logic with_cmp,
                               input logic [9:0] caddr, input int exp_wait);
        int waits = 0;
        bit got = 0;
        host_req = 1'b1; host_we = we; host_region = region; host_addr = a; host_wdata = wd;
        if (with_cmp) begin
            cmp_rden = 1'b1;
            cmp_rdaddr = caddr;
        end
        while (!got && waits < 20) begin
            @(negedge clk);
            if (host_ack) got = 1;
            else waits++;
            @(posedge clk); #1;
            cmp_rden = 1'b0;
        end
        host_req = 1'b0;
        if (!got) fail_now("host_ack_timeout");
        else check("ack_latency", waits, exp_wait);
    endtask

    task automatic cmp_read(input logic [9:0] a, input logic [53:0] d);
        cmp_q.push_back('{{bank_exp, a}, d});
        cmp_rden = 1'b1;
        cmp_rdaddr = a;
        @(posedge clk); #1;
        cmp_rden = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_active_bank", active_bank, 1'b0);
        check("rst_commit_pending", commit_pending, 1'b0);
        check("rst_host_ack", host_ack, 1'b0);
        check("rst_host_err", host_err, 1'b0);
        check("rst_host_rvalid", host_rvalid, 1'b0);
        check("rst_host_rdata", host_rdata, 18'h0);
        check("rst_cmp_rddata", cmp_rddata, 54'h0);
        check("rst_ram_rden", ram_rden, 3'b000);
        check("rst_ram_wren", ram_wren, 3'b000);
    endtask

    initial begin
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 2048; i++) mem[r][i] = '0;
            rd_r[r] = '0;
        end
        mem[0][7] = 18'h00ABC;
        mem[1][7] = 18'h11111;
        mem[2][7] = 18'h22222;
        mem[0][1024 + 9]   = 18'h0BEEF;
        mem[2][1024 + 811] = 18'h3FFFF;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;
        rst = 1'b0;

        // Write region1 addr 5 to shadow bank with the compare engine idle.
        push_ack(1'b0, 3'b000, 3'b010, 10'd5, 1'b0, '0);
        host_access(1'b1, 2'd1, 10'd5, 18'h01234, 1'b0, '0, 0);

        // Host and compare in the same cycle: compare first, host the next cycle.
        push_ack(1'b0, 3'b010, 3'b000, 10'd5, 1'b1, 18'h01234);
        cmp_q.push_back('{{bank_exp, 10'd7}, {18'h22222, 18'h11111, 18'h00ABC}});
        host_access(1'b0, 2'd1, 10'd5, '0, 1'b1, 10'd7, 1);
        idle(3);

        // Compare read then host read: compare data must hold through host read.
        cmp_read(10'd7, {18'h22222, 18'h11111, 18'h00ABC});
        push_ack(1'b0, 3'b001, 3'b000, 10'd9, 1'b1, 18'h0BEEF);
        host_access(1'b0, 2'd0, 10'd9, '0, 1'b0, '0, 0);
        idle(3);

        // Last valid point, then out-of-range address and region.
        push_ack(1'b0, 3'b100, 3'b000, 10'd811, 1'b1, 18'h3FFFF);
        host_access(1'b0, 2'd2, 10'd811, '0, 1'b0, '0, 0);
        idle(3);
        push_ack(1'b1, 3'b000, 3'b000, 10'd812, 1'b1, '0);
        host_access(1'b0, 2'd0, 10'd812, '0, 1'b0, '0, 0);
        push_ack(1'b1, 3'b000, 3'b000, 10'd1, 1'b0, '0);
        host_access(1'b1, 2'd3, 10'd1, 18'h15555, 1'b0, '0, 0);
        idle(4);

        // Commit during a scan: host stalls, bank holds until cycle_enable falls.
        commit = 1'b1;
        cycle_enable = 1'b1;
        @(posedge clk); #1;
        commit = 1'b0;
        host_req = 1'b1; host_we = 1'b1; host_region = 2'd0; host_addr = 10'd3;
        host_wdata = 18'h00777;
        repeat (6) begin
            @(negedge clk);
            check("stall_no_ack", host_ack, 1'b0);
            check("stall_pending", commit_pending, 1'b1);
            check("stall_bank", active_bank, 1'b0);
            @(posedge clk); #1;
        end
        cycle_enable = 1'b0;
        ack_q.push_back('{1'b0, 3'b000, 3'b001, 11'h003, 1'b0, 18'h0});
        host_access(1'b1, 2'd0, 10'd3, 18'h00777, 1'b0, '0, 2);
        bank_exp = 1'b1;
        @(negedge clk);
        check("swap_bank", active_bank, 1'b1);
        check("swap_pending_clear", commit_pending, 1'b0);
        @(posedge clk); #1;
        cmp_read(10'd5, {18'h0, 18'h01234, 18'h0});
        idle(3);

        // Reset one cycle after a read grant abandons the read.
        push_ack(1'b0, 3'b010, 3'b000, 10'd5, 1'b1, 18'h0);
        host_access(1'b0, 2'd1, 10'd5, '0, 1'b0, '0, 0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_no_rvalid", host_rvalid, 1'b0);
        @(posedge clk); #1;
        bank_exp = 1'b0;
        rst = 1'b0;
        push_ack(1'b0, 3'b000, 3'b100, 10'd10, 1'b0, '0);
        host_access(1'b1, 2'd2, 10'd10, 18'h2AAAA, 1'b0, '0, 0);
        idle(4);
        push_ack(1'b0, 3'b100, 3'b000, 10'd10, 1'b1, 18'h2AAAA);
        host_access(1'b0, 2'd2, 10'd10, '0, 1'b0, '0, 0);
        idle(5);

        check("ack_queue_drained", ack_q.size(), 0);
        check("rdata_queue_drained", due_q.size(), 0);
        check("cmp_queue_drained", cmp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
